// File: rtl/neuron_backward_pkg.sv
// Shared constants and types for the neuron backward (ReLU gating) stage.
// Holds mode encoding and default lane geometry.
package neuron_backward_pkg;

  typedef enum logic {
    MODE_INFER = 1'b0,
    MODE_TRAIN = 1'b1
  } mode_e;

  localparam int NB_NC    = 4;
  localparam int NB_WF    = 4;
  localparam int NB_WD    = 8;
  localparam int NB_DEPTH = 4;

  typedef struct packed {
    logic push;
    logic pop;
    logic clear;
  } fifoCtl_t;

endpackage

// File: rtl/neuron_backward_state_fifo.sv
// Synchronous state FIFO with async active-low reset and sync clear.
// Ports: clk, rst_n, ctl{push,pop,clear}, wrData, rdData, full, empty.
module neuron_backward_state_fifo
  import neuron_backward_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  fifoCtl_t         ctl,
  input  logic [WIDTH-1:0] wrData,
  output logic [WIDTH-1:0] rdData,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wrPtr;
  logic [AW-1:0]    rdPtr;
  logic [AW:0]      count;
  logic             doPush;
  logic             doPop;

  assign full   = (count == (AW+1)'(DEPTH));
  assign empty  = (count == '0);
  assign doPush = ctl.push && !full;
  assign doPop  = ctl.pop && !empty;
  assign rdData = mem[rdPtr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else if (ctl.clear) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + 1'b1;
      if (doPop)  rdPtr <= rdPtr + 1'b1;
      if (doPush && !doPop)
        count <= count + 1'b1;
      else if (doPop && !doPush)
        count <= count - 1'b1;
    end
  end

  // Storage needs no reset: entries are only read when counted.
  always_ff @(posedge clk) begin
    if (doPush && !ctl.clear)
      mem[wrPtr] <= wrData;
  end

endmodule

// File: rtl/neuron_backward.sv
// Backward ReLU stage: stores forward states, gates deltas by ReLU'.
// Ports: State in (AM), Delta in (AM), gated Delta out (BM), iMode.
module neuron_backward
  import neuron_backward_pkg::*;
#(
  parameter int NC    = NB_NC,
  parameter int WF    = NB_WF,
  parameter int WD    = NB_WD,
  parameter int DEPTH = NB_DEPTH
) (
  input  logic           iCLK,
  input  logic           iRST,
  input  logic           iMode,
  input  logic           iValid_AM_State,
  output logic           oReady_AM_State,
  input  logic [NC*WF-1:0] iData_AM_State,
  input  logic           iValid_AM_Delta,
  output logic           oReady_AM_Delta,
  input  logic [NC*WD-1:0] iData_AM_Delta,
  output logic           oValid_BM_Delta,
  input  logic           iReady_BM_Delta,
  output logic [NC*WD-1:0] oData_BM_Delta
);

  logic             train;
  logic             full;
  logic             empty;
  logic             popXfer;
  logic [NC*WF-1:0] head;
  logic [NC*WD-1:0] gated;
  fifoCtl_t         ctl;

  assign train = (iMode == MODE_TRAIN);

  // Ready tracks full only, so a same-cycle pop never frees a slot.
  assign oReady_AM_State = train ? !full : 1'b1;

  assign oReady_AM_Delta = train && !empty &&
    (!oValid_BM_Delta || iReady_BM_Delta);

  assign popXfer = iValid_AM_Delta && oReady_AM_Delta;

  always_comb begin
    ctl       = '0;
    ctl.push  = train && iValid_AM_State && oReady_AM_State;
    ctl.pop   = popXfer;
    ctl.clear = !train;
  end

  neuron_backward_state_fifo #(
    .WIDTH(NC*WF),
    .DEPTH(DEPTH)
  ) uFifo (
    .clk   (iCLK),
    .rst_n (iRST),
    .ctl   (ctl),
    .wrData(iData_AM_State),
    .rdData(head),
    .full  (full),
    .empty (empty)
  );

  // Pass delta only where the stored state is strictly positive.
  for (genvar c = 0; c < NC; c++) begin : gLane
    logic [WF-1:0] y;
    logic          pos;
    assign y   = head[c*WF +: WF];
    assign pos = !y[WF-1] && (|y);
    assign gated[c*WD +: WD] =
      pos ? iData_AM_Delta[c*WD +: WD] : '0;
  end

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      oValid_BM_Delta <= 1'b0;
      oData_BM_Delta  <= '0;
    end else if (!train) begin
      oValid_BM_Delta <= 1'b0;
    end else if (popXfer) begin
      oValid_BM_Delta <= 1'b1;
      oData_BM_Delta  <= gated;
    end else if (iReady_BM_Delta) begin
      oValid_BM_Delta <= 1'b0;
    end
  end

endmodule

// File: tb/tb_neuron_backward.sv
// Self-checking bench for neuron_backward.
// Queue-based reference model plus directed literal checks.
module tb_neuron_backward;
  import neuron_backward_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        mode;
  logic        vS;
  logic        rS;
  logic [15:0] dS;
  logic        vD;
  logic        rD;
  logic [31:0] dD;
  logic        oV;
  logic        bmRdy;
  logic [31:0] oD;

  int nChecks = 0;
  int nFails  = 0;

  neuron_backward dut (
    .iCLK           (clk),
    .iRST           (rst_n),
    .iMode          (mode),
    .iValid_AM_State(vS),
    .oReady_AM_State(rS),
    .iData_AM_State (dS),
    .iValid_AM_Delta(vD),
    .oReady_AM_Delta(rD),
    .iData_AM_Delta (dD),
    .oValid_BM_Delta(oV),
    .iReady_BM_Delta(bmRdy),
    .oData_BM_Delta (oD)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  function automatic logic [31:0] relu(
    input logic [15:0] s, input logic [31:0] d);
    logic [31:0]       r;
    logic signed [3:0] y;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      y = s[c*4 +: 4];
      if (y > 0) r[c*8 +: 8] = d[c*8 +: 8];
    end
    return r;
  endfunction

  // Reference model: list of stored states and one output slot.
  logic [15:0] q[$];
  logic        mValid;
  logic [31:0] mData;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      mValid = 1'b0;
      mData  = '0;
    end else if (mode != MODE_TRAIN) begin
      q.delete();
      mValid = 1'b0;
    end else begin
      bit okS, okD;
      okS = q.size() < 4;
      okD = q.size() > 0 && (!mValid || bmRdy);
      if (vD && okD) begin
        mData  = relu(q.pop_front(), dD);
        mValid = 1'b1;
      end else if (mValid && bmRdy) begin
        mValid = 1'b0;
      end
      if (vS && okS) q.push_back(dS);
    end
  end

  initial begin
    @(negedge rst_n);
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        check("rstValid", 64'(oV), 64'(0));
        check("rstData", 64'(oD), 64'(0));
      end else begin
        bit t;
        t = (mode == MODE_TRAIN);
        check("valid", 64'(oV), 64'(mValid));
        check("readyState", 64'(rS),
              64'(!t || q.size() < 4));
        check("readyDelta", 64'(rD),
              64'(t && q.size() > 0 &&
                  (!mValid || bmRdy)));
        if (mValid)
          check("data", 64'(oD), 64'(mData));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Keeps delta data stable until it is accepted.
  task automatic deltaStep();
    bit acc;
    acc = vD && rD;
    step();
    if (acc) dD = $urandom;
  endtask

  initial begin
    rst_n = 1'b1;
    mode  = MODE_TRAIN;
    vS = 0; dS = '0; vD = 0; dD = '0; bmRdy = 0;
    #1 rst_n = 1'b0;

    // Reset
    repeat (3) step();
    check("t1Valid", 64'(oV), 64'(0));
    check("t1Data", 64'(oD), 64'(0));
    rst_n = 1'b1;
    #1;
    check("t1ReadyS", 64'(rS), 64'(1));
    check("t1ReadyD", 64'(rD), 64'(0));

    // Gating
    vS = 1; dS = 16'h703F;
    step();
    vS = 0;
    vD = 1; dD = 32'h1020_F005; bmRdy = 1;
    step();
    vD = 0;
    check("t2Valid", 64'(oV), 64'(1));
    check("t2Data", 64'(oD), 64'(32'h1000_F000));
    step();

    // Full
    vS = 1;
    for (int i = 0; i < 4; i++) begin
      dS = 16'($urandom);
      step();
    end
    check("t3Full", 64'(rS), 64'(0));
    dS = 16'($urandom);
    repeat (2) step();
    check("t3Held", 64'(rS), 64'(0));
    vD = 1; dD = $urandom;
    step();
    vD = 0;
    check("t3Freed", 64'(rS), 64'(1));
    step();
    vS = 0;
    check("t3Refull", 64'(rS), 64'(0));
    vD = 1;
    repeat (4) deltaStep();
    vD = 0;
    step();

    // Order and backpressure
    vS = 1;
    repeat (3) begin
      dS = 16'($urandom);
      step();
    end
    vS = 0;
    bmRdy = 0; vD = 1; dD = $urandom;
    deltaStep();
    repeat (3) begin
      check("t4Stall", 64'(rD), 64'(0));
      deltaStep();
    end
    bmRdy = 1;
    repeat (3) deltaStep();
    vD = 0;
    step();

    // Mode exit
    vS = 1;
    repeat (3) begin
      dS = 16'($urandom);
      step();
    end
    vS = 0; bmRdy = 0; vD = 1;
    step();
    vD = 0;
    check("t5PreValid", 64'(oV), 64'(1));
    mode = MODE_INFER;
    step();
    check("t5Valid", 64'(oV), 64'(0));
    check("t5ReadyD", 64'(rD), 64'(0));
    check("t5ReadyS", 64'(rS), 64'(1));
    vS = 1;
    repeat (2) step();
    vS = 0; mode = MODE_TRAIN;
    #1;
    check("t5Empty", 64'(rD), 64'(0));
    step();

    // Async reset mid-burst
    for (int i = 0; i < 20; i++) begin
      vS = 1'($urandom); dS = 16'($urandom);
      vD = 1'($urandom); dD = $urandom;
      bmRdy = 1'($urandom);
      step();
    end
    vS = 1; vD = 1; bmRdy = 0;
    step();
    step();
    #2 rst_n = 1'b0;
    #1;
    check("t6AsyncValid", 64'(oV), 64'(0));
    vS = 0; vD = 0;
    step();
    rst_n = 1'b1;
    #1;
    check("t6Empty", 64'(rD), 64'(0));
    vS = 1; dS = 16'h1807;
    step();
    vS = 0;
    vD = 1; dD = 32'hAABB_CCDD; bmRdy = 1;
    step();
    vD = 0;
    check("t6Data", 64'(oD), 64'(32'hAA00_00DD));
    step();

    // Randomized traffic with occasional mode drops
    for (int i = 0; i < 1500; i++) begin
      mode  = ($urandom_range(0, 49) != 0)
              ? MODE_TRAIN : MODE_INFER;
      vS    = 1'($urandom);
      dS    = 16'($urandom);
      vD    = 1'($urandom);
      dD    = $urandom;
      bmRdy = ($urandom_range(0, 3) != 0);
      step();
    end

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures",
             nChecks, nFails);
    $finish;
  end

endmodule
